alu_iter: RTL and testbench
===========================

# alu_iter

Parametrised multi-cycle ALU built around a SLICE_W-bit slice that iterates LSB-first across a WIDTH-bit operand pair, chaining carry through a register. It generalises the 1-bit op slice into a full-width datapath unit with valid/ready handshakes on both sides. It sits between the GLCPU decode/issue stage and writeback, so a narrow slice can serve a wide datapath at a fixed latency.

## Interface
- WIDTH, 8: operand/result width; must be a multiple of SLICE_W.
- SLICE_W, 2: bits processed per cycle. N = WIDTH/SLICE_W iterations.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  high only in IDLE.
- op  in  5  opcode.
- r, s  in  WIDTH  operands.
- c_in  in  1  carry in, used by ADC/SBC only.
- out_valid  out  1  result valid, held until accepted.
- out_ready  in  1  consumer accepts.
- result  out  WIDTH  result.
- c_out, zero, neg, ovf  out  1 each  flags.
- busy  out  1  high in RUN.

## Operation
- Opcodes:
  - 0 ADD: r+s, carry-in 0.
  - 1 ADC: r+s+c_in.
  - 2 SUB: r+~s+1.
  - 3 SBC: r+~s+c_in.
  - 4 AND, 5 OR, 6 XOR.
  - 7 NOT: ~r.
  - 8 PASS: s.
  - 9–31 reserved: result 0.
- Carry convention for SUB/SBC: c_out=1 means no borrow.
- Flags:
  - zero = (result == 0).
  - neg = result[WIDTH-1].
  - c_out: carry out of the MSB for ops 0–3; 0 for all other ops.
  - ovf: signed overflow (carry into MSB XOR carry out of MSB) for ops 0–3; 0 for all other ops.
- States:
  - IDLE: in_ready=1. On in_valid, latch op, r, s and initial carry; clear the iteration counter; go to RUN.
  - RUN: each cycle, compute slice [cnt*SLICE_W +: SLICE_W] and store it into result_reg; update the carry register; increment cnt. After the slice with cnt==N-1, latch flags and go to DONE.
  - DONE: out_valid=1. When out_ready is high, return to IDLE.
- Operand/result registers are not cleared between operations. Only the outputs listed under Timing have reset values.

## Timing
- Reset (async, rst_n low): state=IDLE, cnt=0, result=0, all flags=0, out_valid=0, busy=0, in_ready=1 once rst_n releases.
- Acceptance edge = rising edge with in_valid && in_ready.
- out_valid rises exactly N cycles after the acceptance edge. Example: WIDTH=8, SLICE_W=2 gives 4 cycles; SLICE_W=WIDTH gives 1 cycle.
- result and flags are stable and valid whenever out_valid=1. They hold their values after the handshake until the next completion.
- in_valid during RUN or DONE is ignored (in_ready=0); the requester must hold it.
- Back-to-back operations: the DONE→IDLE handshake edge does not accept new input. Minimum issue interval is N+2 cycles.
- rst_n asserted mid-RUN or in DONE: abort immediately to reset values; the partial result is discarded.
- op, r, s and c_in are sampled only at the acceptance edge. Later input changes have no effect.

## Configuration
- ALU_ITER_OVF_EN defined: the ovf flag is computed as above.
- ALU_ITER_OVF_EN undefined: ovf is tied to 0 and the MSB carry-in tracking logic is removed. All other outputs are identical in both builds.

## Structure
- Package alu_iter_pkg holds:
  - opcode localparams (OP_ADD … OP_PASS);
  - the state enum typedef (IDLE, RUN, DONE);
  - a function is_arith(op) returning true for ops 0–3.
- One sub-module, alu_slice_w (parameter SLICE_W), combinational:
  - inputs: op, r/s slices, carry in;
  - outputs: result slice, carry out, carry into the top bit of the slice (for ovf).
  - The top-level FSM instantiates one alu_slice_w.

## Test plan
All cases use WIDTH=8, SLICE_W=2 unless stated.
- ADD 0xFF+0x01 → result 0x00, c_out=1, zero=1, ovf=0; out_valid exactly 4 cycles after acceptance.
- SUB 0x80−0x01 → result 0x7F, c_out=1, ovf=1 (ovf=0 when ALU_ITER_OVF_EN is undefined), neg=0.
- ADC 0x7F+0x00 with c_in=1 → 0x80, ovf=1, neg=1. AND 0xF0&0x3C → 0x30, c_out=0. Reserved op 0x1F → result 0x00, zero=1.
- Backpressure: hold out_ready=0 for 5 cycles → out_valid and result stable, in_ready=0; release → IDLE next cycle, new op accepted the cycle after.
- Reset pulse at RUN iteration 2 → out_valid=0, result=0, in_ready=1; the next ADD 0x12+0x34 completes to 0x46.
- SLICE_W=8 build: XOR 0xAA^0xFF → 0x55, out_valid 1 cycle after acceptance.

Source files
------------

// File: rtl/alu_iter_pkg.sv
// alu_iter_pkg: shared definitions for the iterative slice ALU.
//   - opcode constants OP_ADD .. OP_PASS (5-bit opcode space; 9..31 reserved)
//   - state_t : controller states IDLE / RUN / DONE
//   - is_arith(): true for the carry-chain opcodes ADD, ADC, SUB, SBC
package alu_iter_pkg;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_ADC  = 5'd1;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_SBC  = 5'd3;
  localparam logic [4:0] OP_AND  = 5'd4;
  localparam logic [4:0] OP_OR   = 5'd5;
  localparam logic [4:0] OP_XOR  = 5'd6;
  localparam logic [4:0] OP_NOT  = 5'd7;
  localparam logic [4:0] OP_PASS = 5'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_arith(input logic [4:0] op);
    return (op <= OP_SBC);
  endfunction

endpackage

// File: rtl/alu_iter_slice.sv
// alu_slice_w: combinational SLICE_W-bit ALU slice.
// Ports:
//   op        in   opcode
//   r, s      in   operand slices
//   carry_in  in   carry into bit 0 of the slice
//   res       out  result slice (0 for reserved opcodes)
//   carry_out out  carry out of the slice top bit (0 for non-arithmetic ops)
//   carry_msb out  carry into the slice top bit; present only when
//                  ALU_ITER_OVF_EN is defined
module alu_slice_w
  import alu_iter_pkg::*;
#(
  parameter int SLICE_W = 2
) (
  input  logic [4:0]         op,
  input  logic [SLICE_W-1:0] r,
  input  logic [SLICE_W-1:0] s,
  input  logic               carry_in,
  output logic [SLICE_W-1:0] res,
  output logic               carry_out
`ifdef ALU_ITER_OVF_EN
  ,
  output logic               carry_msb
`endif
);

  logic [SLICE_W-1:0] b;
  logic [SLICE_W-1:0] sum;
  logic [SLICE_W:0]   chain;

  // Ripple adder; subtraction is r + ~s + carry, the carry supplying the +1.
  always_comb begin
    b        = (op == OP_SUB || op == OP_SBC) ? ~s : s;
    sum      = '0;
    chain    = '0;
    chain[0] = carry_in;
    for (int i = 0; i < SLICE_W; i++) begin
      sum[i]       = r[i] ^ b[i] ^ chain[i];
      chain[i+1]   = (r[i] & b[i]) | (chain[i] & (r[i] ^ b[i]));
    end
  end

  always_comb begin
    res       = '0;
    carry_out = 1'b0;
    case (op)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
        res       = sum;
        carry_out = chain[SLICE_W];
      end
      OP_AND:  res = r & s;
      OP_OR:   res = r | s;
      OP_XOR:  res = r ^ s;
      OP_NOT:  res = ~r;
      OP_PASS: res = s;
      default: res = '0;
    endcase
  end

`ifdef ALU_ITER_OVF_EN
  assign carry_msb = is_arith(op) ? chain[SLICE_W-1] : 1'b0;
`endif

endmodule

// File: rtl/alu_iter.sv
// alu_iter: multi-cycle ALU iterating one SLICE_W-bit slice LSB-first over
// WIDTH-bit operands, carry chained through a register. Latency is
// N = WIDTH/SLICE_W cycles from acceptance to out_valid.
// Build option: define ALU_ITER_OVF_EN to compute the signed-overflow flag;
// otherwise ovf is tied to 0 and the MSB carry-in tracking is absent.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid / in_ready   request handshake (in_ready high only in IDLE)
//   op, r, s, c_in        opcode, operands, carry in (ADC/SBC); sampled on accept
//   out_valid / out_ready result handshake (out_valid held until accepted)
//   result                WIDTH-bit result, held until the next completion
//   c_out, zero, neg, ovf flags, latched with result
//   busy                  high while iterating
//
// state | meaning
// IDLE  | waiting for a request, in_ready=1
// RUN   | one slice per cycle, cnt = slice index
// DONE  | result presented, waiting for out_ready
module alu_iter
  import alu_iter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SLICE_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] s,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             busy
);

  localparam int N     = WIDTH / SLICE_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic [4:0]         op_reg;
  logic [WIDTH-1:0]   r_reg, s_reg;
  logic [WIDTH-1:0]   acc, acc_next;
  logic               carry, carry_init;
  logic               accept, last;
  int                 lsb;
  logic [SLICE_W-1:0] r_sl, s_sl, res_sl;
  logic               sl_cout;
`ifdef ALU_ITER_OVF_EN
  logic               sl_cmsb;
`endif

  assign accept = in_valid && in_ready;
  assign last   = (state == RUN) && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == CNT_LAST) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    case (op)
      OP_ADC, OP_SBC: carry_init = c_in;
      OP_SUB:         carry_init = 1'b1;
      default:        carry_init = 1'b0;
    endcase
  end

  always_comb begin
    lsb                      = int'(cnt) * SLICE_W;
    r_sl                     = r_reg[lsb +: SLICE_W];
    s_sl                     = s_reg[lsb +: SLICE_W];
    acc_next                 = acc;
    acc_next[lsb +: SLICE_W] = res_sl;
  end

  alu_slice_w #(.SLICE_W(SLICE_W)) u_slice (
    .op        (op_reg),
    .r         (r_sl),
    .s         (s_sl),
    .carry_in  (carry),
    .res       (res_sl),
    .carry_out (sl_cout)
`ifdef ALU_ITER_OVF_EN
    ,
    .carry_msb (sl_cmsb)
`endif
  );

  // Operand and working registers carry no reset; they are always loaded
  // before being used.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_reg <= op;
      r_reg  <= r;
      s_reg  <= s;
    end
    if (state == RUN) acc <= acc_next;
  end

  // result/flags update only on completion so they stay valid through the
  // following operation's RUN phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      carry  <= 1'b0;
      result <= '0;
      c_out  <= 1'b0;
      zero   <= 1'b0;
      neg    <= 1'b0;
    end else if (accept) begin
      cnt   <= '0;
      carry <= carry_init;
    end else if (state == RUN) begin
      cnt   <= cnt + CNT_W'(1);
      carry <= sl_cout;
      if (last) begin
        result <= acc_next;
        c_out  <= sl_cout;
        zero   <= (acc_next == '0);
        neg    <= acc_next[WIDTH-1];
      end
    end
  end

`ifdef ALU_ITER_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ovf <= 1'b0;
    else if (last) ovf <= is_arith(op_reg) & (sl_cout ^ sl_cmsb);
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_alu_iter.sv
module tb_alu_iter;

`ifdef ALU_ITER_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, out_ready, c_in;
  logic [4:0] op;
  logic [7:0] r, s;
  logic       in_ready, out_valid, c_out, zero, neg, ovf, busy;
  logic [7:0] result;

  logic       in_valid8, out_ready8;
  logic       in_ready8, out_valid8, c_out8, zero8, neg8, ovf8, busy8;
  logic [7:0] result8;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_iter #(.WIDTH(8), .SLICE_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .r(r), .s(s), .c_in(c_in), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .c_out(c_out), .zero(zero),
    .neg(neg), .ovf(ovf), .busy(busy)
  );

  alu_iter #(.WIDTH(8), .SLICE_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .op(op), .r(r), .s(s), .c_in(c_in), .out_valid(out_valid8),
    .out_ready(out_ready8), .result(result8), .c_out(c_out8), .zero(zero8),
    .neg(neg8), .ovf(ovf8), .busy(busy8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op, scramble inputs after acceptance, wait for completion and
  // check latency, result and flags. Leaves the DUT in DONE.
  task automatic run_op(input string tag, input logic [4:0] o, input logic [7:0] a,
                        input logic [7:0] b, input logic ci, input logic [7:0] er,
                        input logic ec, input logic ez, input logic en, input logic ev);
    int lat;
    @(negedge clk);
    op = o; r = a; s = b; c_in = ci; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 5'd8; r = 8'h00; s = 8'hC3; c_in = ~ci;
    chk({tag, "_busy"}, busy, 1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"},    lat,    4);
    chk({tag, "_result"}, result, er);
    chk({tag, "_cout"},   c_out,  ec);
    chk({tag, "_zero"},   zero,   ez);
    chk({tag, "_neg"},    neg,    en);
    chk({tag, "_ovf"},    ovf,    ev & OVF_ON);
  endtask

  task automatic ack(input string tag);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk({tag, "_ack_idle"},  in_ready,  1);
    chk({tag, "_ack_ovld"},  out_valid, 0);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_valid8 = 1'b0;
    out_ready8 = 1'b0; op = 5'd0; r = 8'h00; s = 8'h00; c_in = 1'b0;
    #12;
    chk("rst_in_ready", in_ready,  1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy",     busy,      0);
    chk("rst_result",   result,    0);
    chk("rst_flags",    {c_out, zero, neg, ovf}, 0);
    @(negedge clk); rst_n = 1'b1;

    //      tag       op     r      s      ci    result c  z  n  v
    run_op("add_ff",  5'd0,  8'hFF, 8'h01, 1'b0, 8'h00, 1, 1, 0, 0); ack("add_ff");
    run_op("sub_80",  5'd2,  8'h80, 8'h01, 1'b0, 8'h7F, 1, 0, 0, 1); ack("sub_80");
    run_op("adc_7f",  5'd1,  8'h7F, 8'h00, 1'b1, 8'h80, 0, 0, 1, 1); ack("adc_7f");
    run_op("and",     5'd4,  8'hF0, 8'h3C, 1'b1, 8'h30, 0, 0, 0, 0); ack("and");
    run_op("rsvd",    5'h1F, 8'hAB, 8'hCD, 1'b1, 8'h00, 0, 1, 0, 0); ack("rsvd");
    run_op("or",      5'd5,  8'h0F, 8'h30, 1'b0, 8'h3F, 0, 0, 0, 0); ack("or");
    run_op("xor",     5'd6,  8'hAA, 8'h0F, 1'b0, 8'hA5, 0, 0, 1, 0); ack("xor");
    run_op("not",     5'd7,  8'h0F, 8'h99, 1'b0, 8'hF0, 0, 0, 1, 0); ack("not");
    run_op("sbc_c0",  5'd3,  8'h10, 8'h10, 1'b0, 8'hFF, 0, 0, 1, 0); ack("sbc_c0");
    run_op("sbc_c1",  5'd3,  8'h10, 8'h10, 1'b1, 8'h00, 1, 1, 0, 0); ack("sbc_c1");
    run_op("add_ovf", 5'd0,  8'h7F, 8'h01, 1'b0, 8'h80, 0, 0, 1, 1); ack("add_ovf");
    run_op("sub_brw", 5'd2,  8'h00, 8'h01, 1'b0, 8'hFF, 0, 0, 1, 0); ack("sub_brw");
    run_op("pass",    5'd8,  8'h11, 8'h5A, 1'b0, 8'h5A, 0, 0, 0, 0);

    // Backpressure with a pending request held during DONE.
    @(negedge clk);
    op = 5'd0; r = 8'h01; s = 8'h02; c_in = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_result",    result,    8'h5A);
      chk("bp_in_ready",  in_ready,  0);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk("bp_rel_idle",   in_ready, 1);
    chk("bp_rel_busy",   busy,     0);
    chk("bp_rel_result", result,   8'h5A);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_next_busy",  busy,   1);
    chk("bp_hold_result", result, 8'h5A);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_next_lat",    lat,    4);
    chk("bp_next_result", result, 8'h03);
    ack("bp_next");

    // Reset during RUN iteration 2.
    @(negedge clk);
    op = 5'd0; r = 8'hFF; s = 8'h01; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_out_valid", out_valid, 0);
    chk("mid_result",    result,    0);
    chk("mid_in_ready",  in_ready,  1);
    chk("mid_busy_clr",  busy,      0);
    @(negedge clk); rst_n = 1'b1;
    run_op("add_post", 5'd0, 8'h12, 8'h34, 1'b0, 8'h46, 0, 0, 0, 0); ack("add_post");

    // Full-width slice instance: one-cycle latency.
    @(negedge clk);
    op = 5'd6; r = 8'hAA; s = 8'hFF; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0; r = 8'h00;
    chk("w8_busy",      busy8,      1);
    chk("w8_ovld_early", out_valid8, 0);
    @(posedge clk); #1;
    chk("w8_out_valid", out_valid8, 1);
    chk("w8_result",    result8,    8'h55);
    chk("w8_flags",     {c_out8, zero8, neg8, ovf8}, 0);
    @(negedge clk); out_ready8 = 1'b1;
    @(posedge clk); #1; out_ready8 = 1'b0;
    chk("w8_ack_idle",  in_ready8,  1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
